// File: rtl/nco_pkg.sv
// Shared types and default widths for the multi-waveform NCO.
package nco_pkg;

   typedef enum logic [1:0] {
      NCO_SAW    = 2'd0,
      NCO_TRI    = 2'd1,
      NCO_SQUARE = 2'd2,
      NCO_PULSE  = 2'd3
   } nco_mode_e;

   localparam int NCO_N_DEFAULT     = 8;
   localparam int NCO_ACC_W_DEFAULT = 24;

endpackage

// File: rtl/nco_shaper.sv
// Combinational waveform shaper: maps an accumulator phase to one N-bit sample.
module nco_shaper
   import nco_pkg::*;
#(
   parameter int N     = NCO_N_DEFAULT,
   parameter int ACC_W = NCO_ACC_W_DEFAULT
) (
   input  logic [ACC_W-1:0] phase,
   input  nco_mode_e        mode,
   input  logic [N-1:0]     pw,
   output logic [N-1:0]     sample
);

   logic [N-1:0] top;
   logic [N-1:0] t;
   logic         msb;
   logic         unused_phase_bits;

   assign top = phase[ACC_W-1 -: N];
   assign t   = phase[ACC_W-2 -: N];
   assign msb = phase[ACC_W-1];

   // Low phase bits only matter for accumulation, not for shaping.
   assign unused_phase_bits = ^phase;

   always_comb begin
      sample = '0;
      case (mode)
         NCO_SAW:    sample = top;
         NCO_TRI:    sample = msb ? ~t : t;
         NCO_SQUARE: sample = msb ? '1 : '0;
         NCO_PULSE:  sample = (top < pw) ? '1 : '0;
         default:    sample = '0;
      endcase
   end

endmodule

// File: rtl/nco_multi.sv
// Multi-waveform NCO: phase accumulator with frequency/mode updates deferred to phase wrap.
module nco_multi
   import nco_pkg::*;
#(
   parameter int N     = NCO_N_DEFAULT,
   parameter int ACC_W = NCO_ACC_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             next,
   input  logic [ACC_W-1:0] ftw,
   input  logic             ftw_load,
   input  nco_mode_e        mode,
   input  logic [N-1:0]     pw,
   input  logic             sync,
   output logic [N-1:0]     wave,
   output logic             wave_valid,
   output logic             wrap
);

   logic [ACC_W-1:0] phase_q,    phase_d;
   logic [ACC_W-1:0] ftw_act_q,  ftw_act_d;
   logic [ACC_W-1:0] ftw_pend_q, ftw_pend_d;
   nco_mode_e        mode_act_q, mode_act_d;
   nco_mode_e        mode_pend_q, mode_pend_d;
   logic             pend_flag_q, pend_flag_d;
   logic [N-1:0]     wave_q,     wave_d;
   logic             wave_valid_q, wave_valid_d;
   logic             wrap_q,     wrap_d;

   logic [ACC_W:0]   sum;
   logic             apply_new;
   logic             apply_pend;
   logic [N-1:0]     shaped;

   // sync outranks next; a load coinciding with an apply point bypasses the pending stage.
   always_comb begin
      phase_d      = phase_q;
      ftw_act_d    = ftw_act_q;
      ftw_pend_d   = ftw_pend_q;
      mode_act_d   = mode_act_q;
      mode_pend_d  = mode_pend_q;
      pend_flag_d  = pend_flag_q;
      wave_valid_d = 1'b0;
      wrap_d       = 1'b0;
      apply_new    = 1'b0;
      apply_pend   = 1'b0;
      sum          = {1'b0, phase_q} + {1'b0, ftw_act_q};

      if (sync) begin
         phase_d      = '0;
         wave_valid_d = 1'b1;
         if (ftw_load) begin
            apply_new = 1'b1;
         end else if (pend_flag_q) begin
            apply_pend = 1'b1;
         end
      end else if (next) begin
         phase_d      = sum[ACC_W-1:0];
         wave_valid_d = 1'b1;
         wrap_d       = sum[ACC_W];
         if (sum[ACC_W]) begin
            if (ftw_load) begin
               apply_new = 1'b1;
            end else if (pend_flag_q) begin
               apply_pend = 1'b1;
            end
         end
      end

      if (apply_new) begin
         ftw_act_d   = ftw;
         mode_act_d  = mode;
         pend_flag_d = 1'b0;
      end else if (apply_pend) begin
         ftw_act_d   = ftw_pend_q;
         mode_act_d  = mode_pend_q;
         pend_flag_d = 1'b0;
      end else if (ftw_load) begin
         ftw_pend_d  = ftw;
         mode_pend_d = mode;
         pend_flag_d = 1'b1;
      end
   end

   // The sample is shaped from the post-update phase and whichever mode is active after this step.
   nco_shaper #(
      .N     (N),
      .ACC_W (ACC_W)
   ) u_shaper (
      .phase  (phase_d),
      .mode   (mode_act_d),
      .pw     (pw),
      .sample (shaped)
   );

   always_comb begin
      wave_d = wave_q;
      if (sync || next) begin
         wave_d = shaped;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q      <= '0;
         ftw_act_q    <= '0;
         ftw_pend_q   <= '0;
         mode_act_q   <= NCO_SAW;
         mode_pend_q  <= NCO_SAW;
         pend_flag_q  <= 1'b0;
         wave_q       <= '0;
         wave_valid_q <= 1'b0;
         wrap_q       <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         ftw_act_q    <= ftw_act_d;
         ftw_pend_q   <= ftw_pend_d;
         mode_act_q   <= mode_act_d;
         mode_pend_q  <= mode_pend_d;
         pend_flag_q  <= pend_flag_d;
         wave_q       <= wave_d;
         wave_valid_q <= wave_valid_d;
         wrap_q       <= wrap_d;
      end
   end

   assign wave       = wave_q;
   assign wave_valid = wave_valid_q;
   assign wrap       = wrap_q;

endmodule
